// File: rtl/wptr_full.sv
// Write-side pointer and full/occupancy logic of an asynchronous FIFO.
// Keeps the binary/Gray write pointer, synchronizes the read pointer and derives the status flags.
module wptr_full #(
    parameter int ASIZE    = 4,
    parameter int AFULL_TH = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             wen,
    input  logic [ASIZE:0]   rptr_async,
    input  logic             wovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wcount,
    output logic             woverflow
);

    localparam logic [ASIZE:0] AFULL_LVL = AFULL_TH[ASIZE:0];

    logic [ASIZE:0] wbin;
    logic [ASIZE:0] wbin_next;
    logic [ASIZE:0] wgray_next;
    logic [ASIZE:0] wq1;
    logic [ASIZE:0] wq2;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] wcount_next;
    logic           winc;
    logic           wfull_next;
    logic           walmost_full_next;

    assign waddr = wbin[ASIZE-1:0];

    // Full when the next write pointer has lapped the synchronized read pointer exactly once.
    always_comb begin
        winc       = wen & ~wfull;
        wbin_next  = wbin + {{ASIZE{1'b0}}, winc};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin       = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            rbin[i] = ^(wq2 >> i);
        end
        wfull_next        = (wgray_next == {~wq2[ASIZE:ASIZE-1], wq2[ASIZE-2:0]});
        wcount_next       = wbin_next - rbin;
        walmost_full_next = (wcount_next >= AFULL_LVL);
    end

    // Overflow set takes priority over a simultaneous clear.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wq1          <= '0;
            wq2          <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wcount       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wq1          <= rptr_async;
            wq2          <= wq1;
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
            wcount       <= wcount_next;
            if (wen && wfull) begin
                woverflow <= 1'b1;
            end else if (wovf_clr) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full.sv
// Randomized bench for wptr_full against an occupancy-counting reference model.
// The model tracks unbounded write/read counts and a two-deep history of the sampled read count.
module tb_wptr_full;

    localparam int ASIZE    = 4;
    localparam int DEPTH    = 16;
    localparam int AFULL_TH = 12;

    logic             wclk = 1'b0;
    logic             wrst;
    logic             wen;
    logic [ASIZE:0]   rptr_async;
    logic             wovf_clr;
    logic [ASIZE-1:0] waddr;
    logic [ASIZE:0]   wptr;
    logic             wfull;
    logic             walmost_full;
    logic [ASIZE:0]   wcount;
    logic             woverflow;

    int total = 0;
    int bad   = 0;

    // Reference state: counts of accepted writes and of reads issued by the read side.
    int mWr;
    int rdCount;
    int hist1;
    int hist2;
    int mCount;
    bit mFull;
    bit mAf;
    bit mOvf;

    wptr_full #(.ASIZE(ASIZE), .AFULL_TH(AFULL_TH)) dut (
        .wclk(wclk),
        .wrst(wrst),
        .wen(wen),
        .rptr_async(rptr_async),
        .wovf_clr(wovf_clr),
        .waddr(waddr),
        .wptr(wptr),
        .wfull(wfull),
        .walmost_full(walmost_full),
        .wcount(wcount),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [ASIZE:0] toGray(input int v);
        logic [ASIZE:0] b;
        b = v[ASIZE:0];
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("waddr",        32'(waddr),        32'(mWr % DEPTH));
        checkOutput("wptr",         32'(wptr),         32'(toGray(mWr)));
        checkOutput("wfull",        32'(wfull),        32'(mFull));
        checkOutput("walmost_full", 32'(walmost_full), 32'(mAf));
        checkOutput("wcount",       32'(wcount),       32'(mCount));
        checkOutput("woverflow",    32'(woverflow),    32'(mOvf));
    endtask

    // Drives one cycle from the negative edge, updates the model at the rising edge, checks at the next falling edge.
    task automatic applyStimulus(input bit r, input bit w, input bit c);
        logic [ASIZE:0] prevWptr;
        int             rdSampled;
        bit             acc;
        int             occ;
        if (r) rdCount = 0;
        wrst       = r;
        wen        = w;
        wovf_clr   = c;
        rptr_async = toGray(rdCount);
        prevWptr   = wptr;
        rdSampled  = rdCount;
        acc        = w && !r && !mFull;
        @(posedge wclk);
        if (r) begin
            mWr = 0; hist1 = 0; hist2 = 0;
            mCount = 0; mFull = 0; mAf = 0; mOvf = 0;
        end else begin
            if (w && mFull) mOvf = 1;
            else if (c)     mOvf = 0;
            if (acc) mWr++;
            occ    = mWr - hist2;
            mCount = occ;
            mFull  = (occ == DEPTH);
            mAf    = (occ >= AFULL_TH);
            hist2  = hist1;
            hist1  = rdSampled;
        end
        @(negedge wclk);
        checkAll();
        if (!r) begin
            checkOutput("gray_step", 32'($countones(wptr ^ prevWptr)), 32'(acc));
        end
    endtask

    initial begin
        bit w;
        bit c;
        mWr = 0; rdCount = 0; hist1 = 0; hist2 = 0;
        mCount = 0; mFull = 0; mAf = 0; mOvf = 0;
        wrst = 1'b1; wen = 1'b0; wovf_clr = 1'b0; rptr_async = '0;

        // Reset with wen held high must not move the pointer.
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);

        // Fill from empty; almost-full and full thresholds are crossed along the way.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, 0);
            if (i == AFULL_TH - 2) checkOutput("af_not_early", 32'(walmost_full), 32'd0);
        end
        checkOutput("fill_wptr",  32'(wptr),   32'h18);
        checkOutput("fill_count", 32'(wcount), 32'd16);
        checkOutput("fill_full",  32'(wfull),  32'd1);

        // Writes while full are dropped and flagged.
        repeat (3) applyStimulus(0, 1, 0);
        checkOutput("ovf_set", 32'(woverflow), 32'd1);
        applyStimulus(0, 0, 1);
        checkOutput("ovf_clr", 32'(woverflow), 32'd0);
        applyStimulus(0, 1, 1);
        checkOutput("ovf_set_wins", 32'(woverflow), 32'd1);
        applyStimulus(0, 0, 1);

        // One read becomes visible on the third edge.
        rdCount = 1;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("drain_still_full", 32'(wfull), 32'd1);
        applyStimulus(0, 0, 0);
        checkOutput("drain_full", 32'(wfull),  32'd0);
        checkOutput("drain_cnt",  32'(wcount), 32'd15);

        // Mixed traffic with phases biased toward filling and toward draining.
        for (int i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0) w = ($urandom_range(0, 3) != 0);
            else                   w = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 7) == 0);
            if (rdCount < mWr && $urandom_range(0, 1) == 1) rdCount++;
            applyStimulus(0, w, c);
        end

        // Reset in the middle of operation with nine words outstanding.
        applyStimulus(1, 0, 0);
        repeat (9) applyStimulus(0, 1, 0);
        checkOutput("mid_cnt9", 32'(wcount), 32'd9);
        applyStimulus(1, 1, 0);
        checkOutput("mid_rst_addr", 32'(waddr), 32'd0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 Parameter ASIZE, default 4: address width, FIFO depth DEPTH = 2^ASIZE, legal range ASIZE >= 2.
REQ-002 Parameter AFULL_TH, default 12: almost-full threshold in words, legal range 1..DEPTH.
REQ-003 wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 wrst  input  1  reset, synchronous, active-high.
REQ-005 wen  input  1  write request from producer.
REQ-006 rptr_async  input  ASIZE+1  Gray-coded read pointer from the read clock domain, asynchronous to wclk.
REQ-007 wovf_clr  input  1  clears the sticky overflow flag.
REQ-008 waddr  output  ASIZE  memory write address, the low ASIZE bits of the binary write pointer.
REQ-009 wptr  output  ASIZE+1  registered Gray-coded write pointer, exported to the read domain.
REQ-010 wfull  output  1  FIFO full, registered.
REQ-011 walmost_full  output  1  occupancy >= AFULL_TH, registered.
REQ-012 wcount  output  ASIZE+1  write-side occupancy estimate, range 0..DEPTH, registered.
REQ-013 woverflow  output  1  sticky flag; a write was attempted while full.

Function
REQ-014 An accepted write SHALL be wen=1 and wfull=0 at a rising edge; wen=1 with wfull=1 SHALL be dropped with no pointer change.
REQ-015 The binary pointer wbin (ASIZE+1 bits) SHALL increment by 1 per accepted write and wrap modulo 2^(ASIZE+1).
REQ-016 waddr SHALL equal wbin[ASIZE-1:0], so it addresses the same slot the memory writes on that edge.
REQ-017 wptr SHALL be registered as wbin_next XOR (wbin_next >> 1), updated on the same edge as wbin.
REQ-018 wptr SHALL change by exactly one bit per accepted write, with no glitch-generating logic after the register.
REQ-019 rptr_async SHALL pass through a 2-flop synchronizer (wq1, then wq2) clocked by wclk before any use.
REQ-020 wfull_next SHALL be 1 iff the Gray value of wbin_next equals wq2 with its two MSBs inverted and its remaining bits equal.
REQ-021 wfull SHALL be registered from wfull_next, asserting on the same edge that accepts the DEPTH-th outstanding write.
REQ-022 The read-domain binary pointer rbin SHALL be Gray-to-binary of wq2.
REQ-023 wcount SHALL be registered as (wbin_next - rbin) mod 2^(ASIZE+1).
REQ-024 walmost_full SHALL be registered as (wcount_next >= AFULL_TH).
REQ-025 Occupancy is pessimistic, lagging reads by at most 3 wclk edges; wfull and walmost_full SHALL deassert only after the synchronized read pointer advances.
REQ-026 woverflow SHALL set on any edge with wen=1 and wfull=1, and clear on an edge with wovf_clr=1.
REQ-027 When set and clear occur on the same edge, woverflow set SHALL win.
REQ-028 A rptr_async change SHALL affect wfull, wcount and walmost_full at the 3rd rising edge after it is first sampled.

Reset
REQ-029 On wrst=1 at a rising edge: wbin, wq1 and wq2 SHALL go to 0; waddr=0, wptr=0, wfull=0, walmost_full=0, wcount=0, woverflow=0.
REQ-030 While wrst=1, wen SHALL be ignored.
REQ-031 Reset mid-operation SHALL discard pointer state regardless of FIFO contents; the read domain is reset by the system at the same time.
REQ-032 No output SHALL be X after the first reset edge.

Verification
REQ-033 Fill: ASIZE=4, rptr_async=0, wen=1 for 16 edges -> waddr steps 0..15, then reads 0; wptr=5'b11000 and wfull=1 after the 16th edge; wcount=16.
REQ-034 Almost-full: same fill -> walmost_full rises on the edge where wcount becomes 12 (12th write), never earlier.
REQ-035 Overflow: full, wen=1 for 3 edges -> waddr, wptr and wcount unchanged; woverflow=1.
REQ-036 Overflow clear: wovf_clr=1 alone -> woverflow=0 next edge; wovf_clr=1 together with a new overflow -> woverflow stays 1.
REQ-037 Drain and wrap: full, then rptr_async steps to Gray(1)=5'b00001 -> wfull=0 and wcount=15 at the 3rd edge.
REQ-038 Wrap continuity: continue 40 mixed writes and reads -> wptr changes one bit per write; wbin wraps 31->0 with correct wcount.
REQ-039 Mid-operation reset: wrst=1 for 1 edge with wcount=9 -> all outputs 0 next cycle; the first write after reset uses waddr=0.
